// File: rtl/seg7_readback_if.sv
// seg7_readback_if
//   Output side of the seven-segment readback decoder: the captured word,
//   its per-digit invalid flags, the valid/ready handshake and the sticky
//   overrun flag.
//   master : decoder side (drives data_out, digit_invalid, out_valid, overrun)
//   slave  : consumer side (drives out_ready)
interface seg7_readback_if;
  logic [11:0] data_out;
  logic [2:0]  digit_invalid;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;

  modport master (
    output data_out,
    output digit_invalid,
    output out_valid,
    output overrun,
    input  out_ready
  );

  modport slave (
    input  data_out,
    input  digit_invalid,
    input  out_valid,
    input  overrun,
    output out_ready
  );
endinterface

// File: rtl/seg7_readback.sv
// seg7_readback
//   Loopback monitor for the three-digit seven-segment display bus. It
//   watches the active-low segment lines, waits for the pattern to stay
//   stable for STABLE_CYCLES samples, decodes each digit back to a hex
//   nibble and offers the 12-bit result in a one-word output slot.
//
//   Ports
//     clk     : rising-edge clock
//     rst     : synchronous active-high reset
//     seg_H/M/L : segment lines, bit 0 = a .. bit 6 = g, 0 = lit
//     out_if  : output slot (data_out, digit_invalid, out_valid,
//               out_ready, overrun)
//
//   Output slot FSM
//     state    | meaning
//     ---------+----------------------------------------------------
//     ST_EMPTY | no word held; a capture loads the slot
//     ST_FULL  | word held; out_ready frees it, a capture while not
//              | ready is dropped and flagged as overrun
module seg7_readback #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_H,
  input  logic [6:0] seg_M,
  input  logic [6:0] seg_L,
  seg7_readback_if.master out_if
);

  localparam int unsigned CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Returns {invalid, nibble}; unknown glyphs decode to nibble 0.
  function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'h40:   res = 5'h00;
      7'h79:   res = 5'h01;
      7'h24:   res = 5'h02;
      7'h30:   res = 5'h03;
      7'h19:   res = 5'h04;
      7'h12:   res = 5'h05;
      7'h02:   res = 5'h06;
      7'h78:   res = 5'h07;
      7'h00:   res = 5'h08;
      7'h18:   res = 5'h09;
      7'h08:   res = 5'h0A;
      7'h03:   res = 5'h0B;
      7'h46:   res = 5'h0C;
      7'h21:   res = 5'h0D;
      7'h06:   res = 5'h0E;
      7'h0E:   res = 5'h0F;
      default: res = 5'h10;
    endcase
    return res;
  endfunction

  state_t           state_q, state_d;
  logic [20:0]      samp_q, samp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [20:0]      last_pat_q, last_pat_d;
  logic             first_q, first_d;
  logic [11:0]      data_q, data_d;
  logic [2:0]       inv_q, inv_d;
  logic             overrun_q, overrun_d;

  logic [20:0] seg_now;
  logic        capture;
  logic        load;
  logic [4:0]  dec_h, dec_m, dec_l;

  always_comb begin
    seg_now = {seg_H, seg_M, seg_L};
    samp_d  = seg_now;

    if (seg_now == samp_q) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end

    // A pattern identical to the last captured one is never re-offered;
    // first_q lets the very first pattern after reset through regardless.
    capture = (cnt_q == CNT_MAX) && ((samp_q != last_pat_q) || first_q);

    dec_h = decode_glyph(samp_q[20:14]);
    dec_m = decode_glyph(samp_q[13:7]);
    dec_l = decode_glyph(samp_q[6:0]);

    state_d    = state_q;
    data_d     = data_q;
    inv_d      = inv_q;
    last_pat_d = last_pat_q;
    first_d    = first_q;
    overrun_d  = overrun_q;
    load       = 1'b0;

    case (state_q)
      ST_EMPTY: begin
        if (capture) begin
          load    = 1'b1;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_if.out_ready) begin
          if (capture) begin
            load = 1'b1;
          end else begin
            state_d = ST_EMPTY;
          end
        end else if (capture) begin
          // last_pat is left alone so the pattern is still pending when
          // the slot frees.
          overrun_d = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    if (load) begin
      data_d     = {dec_h[3:0], dec_m[3:0], dec_l[3:0]};
      inv_d      = {dec_h[4], dec_m[4], dec_l[4]};
      last_pat_d = samp_q;
      first_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      samp_q     <= '0;
      cnt_q      <= '0;
      last_pat_q <= '0;
      first_q    <= 1'b1;
      data_q     <= '0;
      inv_q      <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      samp_q     <= samp_d;
      cnt_q      <= cnt_d;
      last_pat_q <= last_pat_d;
      first_q    <= first_d;
      data_q     <= data_d;
      inv_q      <= inv_d;
      overrun_q  <= overrun_d;
    end
  end

  assign out_if.data_out      = data_q;
  assign out_if.digit_invalid = inv_q;
  assign out_if.out_valid     = (state_q == ST_FULL);
  assign out_if.overrun       = overrun_q;

endmodule

// File: doc/seg7_readback.md
# seg7_readback

Hex readback decoder for the three-digit seven-segment display bus. It samples the active-low segment lines `seg_H`, `seg_M` and `seg_L` and waits for the pattern to hold stable for a programmable number of cycles. It then decodes each digit back to its 4-bit hex nibble and presents the 12-bit value on a valid/ready interface. It sits beside the display encoder as a loopback/self-test monitor, so firmware or a scoreboard can confirm what the display actually shows.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical samples required before a pattern is accepted; legal range 2..255.
- `clk` input 1: single clock; all logic rising-edge.
- `rst` input 1: reset, synchronous, active-high.
- `seg_H` input 7: high digit segments; bit 0 = a … bit 6 = g, active-low (0 = lit).
- `seg_M` input 7: middle digit, same encoding.
- `seg_L` input 7: low digit, same encoding.
- `data_out` output 12: decoded value {H,M,L} nibbles; bits 11:8 = H.
- `digit_invalid` output 3: per-digit flag, bit 2 = H, bit 1 = M, bit 0 = L; set when the pattern is not a legal glyph.
- `out_valid` output 1: `data_out`/`digit_invalid` hold a captured word.
- `out_ready` input 1: consumer accepts the word on a cycle where `out_valid` and `out_ready` are both high.
- `overrun` output 1: sticky; a new stable pattern was dropped because the output was full.

## Operation
- Glyph table, `seg[6:0]` hex → nibble:
  - 0x40→0, 0x79→1, 0x24→2, 0x30→3, 0x19→4, 0x12→5, 0x02→6, 0x78→7.
  - 0x00→8, 0x18→9, 0x08→A, 0x03→b, 0x46→C, 0x21→d, 0x06→E, 0x0E→F.
- Any other pattern: nibble = 0, corresponding `digit_invalid` bit = 1.
- Sample register `samp` (21 bits) loads {seg_H,seg_M,seg_L} every cycle.
- Stability counter `cnt`, width ceil(log2(STABLE_CYCLES)):
  - inputs == `samp` → `cnt` increments, saturating at STABLE_CYCLES-1;
  - otherwise `cnt` ← 0.
- Capture condition: `cnt` == STABLE_CYCLES-1 AND (`samp` != `last_pat` OR `first` = 1).
  - `last_pat` is the raw 21-bit pattern of the most recent capture.
  - `first` is set by reset and cleared by the first capture.
- Output slot holds one word. Slot states:
  - EMPTY: capture condition → decode `samp` into `data_out`/`digit_invalid`, `out_valid` ← 1, `last_pat` ← `samp`; go to FULL.
  - FULL, `out_ready` = 1: slot frees this cycle. If the capture condition is also true, load the new word in the same cycle; `out_valid` stays 1 and no overrun. Otherwise `out_valid` ← 0; go to EMPTY.
  - FULL, `out_ready` = 0, capture condition true: held word unchanged, `overrun` ← 1. The pattern stays pending (`last_pat` not updated) and is captured once the slot frees, if still stable.
- `data_out`/`digit_invalid` hold their value while FULL and keep the last value while EMPTY.
- Reapplying a pattern identical to `last_pat` never recaptures, even after a glitch; only a different stable pattern captures.

## Timing
- Reset values: `data_out` = 0x000, `digit_invalid` = 3'b000, `out_valid` = 0, `overrun` = 0. Internal reset: `samp` = 0, `cnt` = 0, `first` = 1.
- Reset mid-operation discards the held word and any pending pattern; counting restarts from the edge after `rst` falls.
- Capture latency: a pattern first present before edge 1 and held constant gives `out_valid` high after edge STABLE_CYCLES+1 (edge 5 at default).
- A single-cycle input change restarts the count; capture then needs STABLE_CYCLES+1 edges measured from the first cycle the new value is present.
- Throughput: one word per cycle at most; sustained rate is bounded by the stability window.
- `overrun` clears only on `rst`.

## Test plan
- Reset, then H=0x79, M=0x24, L=0x30 held → `out_valid` rises after edge 5, `data_out` = 0x123, `digit_invalid` = 000; `out_ready` = 1 for one cycle → `out_valid` falls, no recapture while the pattern holds.
- Glitch: 0x40/0x40/0x40 held 3 cycles, L → 0x79 for 1 cycle, then back to 0x40 → no capture until 5 edges after restoration; then `data_out` = 0x000.
- Illegal glyph: H=0x7F, M=0x0E, L=0x03 → `data_out` = 0x0Fb, `digit_invalid` = 3'b100.
- Overrun: capture 0xABC (0x08/0x03/0x46) with `out_ready` = 0, then apply 0xDEF (0x21/0x06/0x0E) stable → `overrun` = 1, `data_out` stays 0xABC. Raise `out_ready` → next word 0xDEF, back-to-back with `out_valid` held high.
- Simultaneous accept and capture: `out_ready` = 1 on the exact edge a new pattern meets the window → word replaced in one cycle, `out_valid` never drops, `overrun` stays 0.
- `rst` asserted while FULL with `overrun` = 1 → all outputs return to reset values next edge. The same prior pattern is recaptured after STABLE_CYCLES+1 edges, because `first` = 1.
